// File: rtl/int_rs.sv
// rtl/int_rs.sv - value-capturing reservation station feeding int_alu
//
// Purpose: holds renamed instructions until their A/B/T operands are ready,
// snoops the CDB for wakeups, and issues the oldest ready entry each cycle.
// Storage is a collapsing queue: entry 0 is oldest, valid entries are
// contiguous from index 0 and count holds the number of valid entries.
//
// Ports:
//   clk, rst            clock, synchronous active-high reset
//   recovery_en         flush all entries, suppress issue and dispatch
//   disp_*              dispatch request, instruction and source tag/rdy/value
//   cdb_pkt, cdb_result, cdb_result_t   CDB broadcast used for wakeup
//   issue_en, issue_inst, rd_a, rd_b, rd_t   selected entry to int_alu
//   count               occupied entries

package int_rs_pkg;
  localparam int XLEN   = 32;
  localparam int PTAG_W = 6;

  typedef struct packed {
    logic [3:0]        op;
    logic              use_imm;
    logic              read_t;
    logic [PTAG_W-1:0] p_rd;
    logic [XLEN-1:0]   imm;
  } Inst_t;

  typedef struct packed {
    logic              valid;
    logic              en;
    logic [PTAG_W-1:0] tag;
    logic              t_en;
    logic [PTAG_W-1:0] t_tag;
  } Cdb_pkt_t;
endpackage

module int_rs #(
  parameter int DEPTH  = 8,
  parameter int PTAG_W = 6
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             recovery_en,
  input  logic                             disp_valid,
  output logic                             disp_ready,
  input  int_rs_pkg::Inst_t                disp_inst,
  input  logic [PTAG_W-1:0]                disp_a_tag,
  input  logic [PTAG_W-1:0]                disp_b_tag,
  input  logic [PTAG_W-1:0]                disp_t_tag,
  input  logic                             disp_a_rdy,
  input  logic                             disp_b_rdy,
  input  logic                             disp_t_rdy,
  input  logic [int_rs_pkg::XLEN-1:0]      disp_a_val,
  input  logic [int_rs_pkg::XLEN-1:0]      disp_b_val,
  input  logic                             disp_t_val,
  input  int_rs_pkg::Cdb_pkt_t             cdb_pkt,
  input  logic [int_rs_pkg::XLEN-1:0]      cdb_result,
  input  logic                             cdb_result_t,
  output logic                             issue_en,
  output int_rs_pkg::Inst_t                issue_inst,
  output logic [int_rs_pkg::XLEN-1:0]      rd_a,
  output logic [int_rs_pkg::XLEN-1:0]      rd_b,
  output logic                             rd_t,
  output logic [$clog2(DEPTH+1)-1:0]       count
);
  localparam int XL = int_rs_pkg::XLEN;
  localparam int CW = $clog2(DEPTH+1);
  localparam int IW = $clog2(DEPTH);

  int_rs_pkg::Inst_t inst_q [DEPTH];
  int_rs_pkg::Inst_t inst_d [DEPTH];
  logic [PTAG_W-1:0] a_tag_q [DEPTH], b_tag_q [DEPTH], t_tag_q [DEPTH];
  logic [PTAG_W-1:0] a_tag_d [DEPTH], b_tag_d [DEPTH], t_tag_d [DEPTH];
  logic [XL-1:0]     a_val_q [DEPTH], b_val_q [DEPTH];
  logic [XL-1:0]     a_val_d [DEPTH], b_val_d [DEPTH];
  logic [DEPTH-1:0]  a_rdy_q, b_rdy_q, t_rdy_q, t_val_q;
  logic [DEPTH-1:0]  a_rdy_d, b_rdy_d, t_rdy_d, t_val_d;
  logic [CW-1:0]     count_q, count_d;

  logic [DEPTH-1:0]  shift;
  logic [IW-1:0]     sel;
  logic              found;
  logic              issued;
  logic              accept;
  logic [CW-1:0]     pos;
  logic              wake_ab, wake_t;

  assign count      = count_q;
  assign disp_ready = (count_q < CW'(DEPTH));
  assign wake_ab    = cdb_pkt.valid && cdb_pkt.en;
  assign wake_t     = cdb_pkt.valid && cdb_pkt.t_en;

  // Select from registered state only. shift[j] marks entries at or above
  // the selected one; they move down one slot when the issue happens.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    shift = '0;
    for (int j = 0; j < DEPTH; j++) begin
      if ((CW'(j) < count_q) && a_rdy_q[j] &&
          (b_rdy_q[j] || inst_q[j].use_imm) &&
          (t_rdy_q[j] || !inst_q[j].read_t) && !found) begin
        found = 1'b1;
        sel   = IW'(j);
      end
      shift[j] = found;
    end
    issued = found && !rst && !recovery_en;
  end

  always_comb begin
    issue_en   = issued;
    issue_inst = '0;
    rd_a       = '0;
    rd_b       = '0;
    rd_t       = 1'b0;
    if (issued) begin
      issue_inst = inst_q[sel];
      rd_a       = a_val_q[sel];
      rd_b       = b_val_q[sel];
      rd_t       = t_val_q[sel];
    end
  end

  // Next state: collapse, then CDB wakeup at post-shift positions, then the
  // dispatch write at the first free post-shift slot (with CDB bypass).
  always_comb begin
    accept = disp_valid && disp_ready && !recovery_en;
    pos    = count_q - CW'(issued);
    for (int j = 0; j < DEPTH; j++) begin
      inst_d[j]  = inst_q[j];
      a_tag_d[j] = a_tag_q[j];
      b_tag_d[j] = b_tag_q[j];
      t_tag_d[j] = t_tag_q[j];
      a_val_d[j] = a_val_q[j];
      b_val_d[j] = b_val_q[j];
      a_rdy_d[j] = a_rdy_q[j];
      b_rdy_d[j] = b_rdy_q[j];
      t_rdy_d[j] = t_rdy_q[j];
      t_val_d[j] = t_val_q[j];
    end
    for (int j = 0; j < DEPTH-1; j++) begin
      if (issued && shift[j]) begin
        inst_d[j]  = inst_q[j+1];
        a_tag_d[j] = a_tag_q[j+1];
        b_tag_d[j] = b_tag_q[j+1];
        t_tag_d[j] = t_tag_q[j+1];
        a_val_d[j] = a_val_q[j+1];
        b_val_d[j] = b_val_q[j+1];
        a_rdy_d[j] = a_rdy_q[j+1];
        b_rdy_d[j] = b_rdy_q[j+1];
        t_rdy_d[j] = t_rdy_q[j+1];
        t_val_d[j] = t_val_q[j+1];
      end
    end
    for (int j = 0; j < DEPTH; j++) begin
      if (accept && (CW'(j) == pos)) begin
        inst_d[j]  = disp_inst;
        a_tag_d[j] = disp_a_tag;
        b_tag_d[j] = disp_b_tag;
        t_tag_d[j] = disp_t_tag;
        a_rdy_d[j] = disp_a_rdy;
        b_rdy_d[j] = disp_b_rdy;
        t_rdy_d[j] = disp_t_rdy;
        a_val_d[j] = disp_a_val;
        b_val_d[j] = disp_b_val;
        t_val_d[j] = disp_t_val;
      end
      // Wakeup covers both surviving entries and the new dispatch (bypass).
      if (!a_rdy_d[j] && wake_ab && (a_tag_d[j] == cdb_pkt.tag)) begin
        a_rdy_d[j] = 1'b1;
        a_val_d[j] = cdb_result;
      end
      if (!b_rdy_d[j] && wake_ab && (b_tag_d[j] == cdb_pkt.tag)) begin
        b_rdy_d[j] = 1'b1;
        b_val_d[j] = cdb_result;
      end
      if (!t_rdy_d[j] && wake_t && (t_tag_d[j] == cdb_pkt.t_tag)) begin
        t_rdy_d[j] = 1'b1;
        t_val_d[j] = cdb_result_t;
      end
    end
    count_d = count_q + CW'(accept) - CW'(issued);
    if (recovery_en) count_d = '0;
  end

  // Entry payload needs no reset: only entries below count are ever looked at.
  always_ff @(posedge clk) begin
    if (rst) count_q <= '0;
    else     count_q <= count_d;
    for (int j = 0; j < DEPTH; j++) begin
      inst_q[j]  <= inst_d[j];
      a_tag_q[j] <= a_tag_d[j];
      b_tag_q[j] <= b_tag_d[j];
      t_tag_q[j] <= t_tag_d[j];
      a_val_q[j] <= a_val_d[j];
      b_val_q[j] <= b_val_d[j];
    end
    a_rdy_q <= a_rdy_d;
    b_rdy_q <= b_rdy_d;
    t_rdy_q <= t_rdy_d;
    t_val_q <= t_val_d;
  end
endmodule

// File: tb/tb_int_rs.sv
// tb/tb_int_rs.sv - self-checking bench for int_rs against a queue model
module tb_int_rs;
  import int_rs_pkg::*;

  logic        clk = 1'b0;
  logic        rst, recovery_en, disp_valid, disp_ready;
  Inst_t       disp_inst;
  logic [5:0]  disp_a_tag, disp_b_tag, disp_t_tag;
  logic        disp_a_rdy, disp_b_rdy, disp_t_rdy;
  logic [31:0] disp_a_val, disp_b_val;
  logic        disp_t_val;
  Cdb_pkt_t    cdb_pkt;
  logic [31:0] cdb_result;
  logic        cdb_result_t;
  logic        issue_en;
  Inst_t       issue_inst;
  logic [31:0] rd_a, rd_b;
  logic        rd_t;
  logic [3:0]  count;

  int_rs #(.DEPTH(8), .PTAG_W(6)) dut (
    .clk(clk), .rst(rst), .recovery_en(recovery_en),
    .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_inst(disp_inst),
    .disp_a_tag(disp_a_tag), .disp_b_tag(disp_b_tag), .disp_t_tag(disp_t_tag),
    .disp_a_rdy(disp_a_rdy), .disp_b_rdy(disp_b_rdy), .disp_t_rdy(disp_t_rdy),
    .disp_a_val(disp_a_val), .disp_b_val(disp_b_val), .disp_t_val(disp_t_val),
    .cdb_pkt(cdb_pkt), .cdb_result(cdb_result), .cdb_result_t(cdb_result_t),
    .issue_en(issue_en), .issue_inst(issue_inst), .rd_a(rd_a), .rd_b(rd_b),
    .rd_t(rd_t), .count(count)
  );

  always #5 clk = ~clk;

  typedef struct {
    Inst_t       inst;
    logic [5:0]  at, bt, tt;
    logic        ar, br, tr;
    logic [31:0] av, bv;
    logic        tv;
  } ent_t;

  ent_t        q[$];
  int          total = 0;
  int          bad = 0;
  logic        s_en, s_t, s_rdy;
  logic [31:0] s_a, s_b;
  logic [3:0]  s_cnt;

  function automatic bit ent_ready(ent_t e);
    return e.ar && (e.br || e.inst.use_imm) && (e.tr || !e.inst.read_t);
  endfunction

  function automatic ent_t wake(ent_t e);
    if (!e.ar && cdb_pkt.valid && cdb_pkt.en && e.at == cdb_pkt.tag) begin
      e.ar = 1'b1; e.av = cdb_result;
    end
    if (!e.br && cdb_pkt.valid && cdb_pkt.en && e.bt == cdb_pkt.tag) begin
      e.br = 1'b1; e.bv = cdb_result;
    end
    if (!e.tr && cdb_pkt.valid && cdb_pkt.t_en && e.tt == cdb_pkt.t_tag) begin
      e.tr = 1'b1; e.tv = cdb_result_t;
    end
    return e;
  endfunction

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: sample and check at negedge, advance the model at posedge.
  task automatic cycle();
    int   idx;
    bit   acc;
    ent_t e;
    @(negedge clk);
    s_en = issue_en; s_a = rd_a; s_b = rd_b; s_t = rd_t;
    s_cnt = count; s_rdy = disp_ready;
    idx = -1;
    if (!rst && !recovery_en)
      foreach (q[i]) if (idx < 0 && ent_ready(q[i])) idx = i;
    chk("issue_en", 64'(issue_en), 64'(idx >= 0));
    if (idx >= 0) begin
      chk("issue_inst", 64'(issue_inst), 64'(q[idx].inst));
      chk("rd_a", 64'(rd_a), 64'(q[idx].av));
      chk("rd_b", 64'(rd_b), 64'(q[idx].bv));
      chk("rd_t", 64'(rd_t), 64'(q[idx].tv));
    end else begin
      chk("issue_inst_zero", 64'(issue_inst), 64'd0);
      chk("rd_ab_zero", 64'({rd_a, rd_b}), 64'd0);
      chk("rd_t_zero", 64'(rd_t), 64'd0);
    end
    chk("count", 64'(count), 64'(q.size()));
    chk("disp_ready", 64'(disp_ready), 64'(q.size() < 8));
    @(posedge clk);
    if (rst || recovery_en) begin
      q.delete();
    end else begin
      acc = disp_valid && (q.size() < 8);
      if (idx >= 0) q.delete(idx);
      foreach (q[i]) q[i] = wake(q[i]);
      if (acc) begin
        e.inst = disp_inst;
        e.at = disp_a_tag; e.bt = disp_b_tag; e.tt = disp_t_tag;
        e.ar = disp_a_rdy; e.br = disp_b_rdy; e.tr = disp_t_rdy;
        e.av = disp_a_val; e.bv = disp_b_val; e.tv = disp_t_val;
        q.push_back(wake(e));
      end
    end
    #1;
  endtask

  task automatic idle();
    recovery_en = 1'b0; disp_valid = 1'b0; disp_inst = '0;
    disp_a_tag = '0; disp_b_tag = '0; disp_t_tag = '0;
    disp_a_rdy = 1'b0; disp_b_rdy = 1'b0; disp_t_rdy = 1'b0;
    disp_a_val = '0; disp_b_val = '0; disp_t_val = 1'b0;
    cdb_pkt = '0; cdb_result = '0; cdb_result_t = 1'b0;
  endtask

  task automatic disp(input logic [3:0] op, input logic ar, input logic [5:0] at,
                      input logic [31:0] av, input logic [31:0] bv);
    disp_valid = 1'b1;
    disp_inst = '0; disp_inst.op = op; disp_inst.p_rd = 6'd40;
    disp_a_rdy = ar; disp_a_tag = at; disp_a_val = av;
    disp_b_rdy = 1'b1; disp_b_tag = 6'd63; disp_b_val = bv;
    disp_t_rdy = 1'b1; disp_t_tag = 6'd63; disp_t_val = 1'b0;
  endtask

  task automatic cdb(input logic [5:0] tag, input logic [31:0] val);
    cdb_pkt = '0; cdb_pkt.valid = 1'b1; cdb_pkt.en = 1'b1; cdb_pkt.tag = tag;
    cdb_result = val;
  endtask

  initial begin
    idle();
    rst = 1'b1;
    // Reset with a dispatch pending: nothing may be stored.
    disp(4'd1, 1'b1, 6'd0, 32'h3, 32'h4);
    cycle(); cycle();
    rst = 1'b0; idle();
    cycle();
    chk("reset_count", 64'(s_cnt), 64'd0);
    chk("reset_issue_en", 64'(s_en), 64'd0);
    chk("reset_disp_ready", 64'(s_rdy), 64'd1);
    chk("reset_rd", 64'({s_a, s_b}), 64'd0);
    cycle();
    chk("reset_nothing_stored", 64'(s_en), 64'd0);

    // Ready dispatch issues the next cycle.
    disp(4'd1, 1'b1, 6'd0, 32'h3, 32'h4); cycle(); idle();
    cycle();
    chk("ready_issue_en", 64'(s_en), 64'd1);
    chk("ready_rd_a", 64'(s_a), 64'd3);
    chk("ready_rd_b", 64'(s_b), 64'd4);
    cycle();
    chk("ready_count_after", 64'(s_cnt), 64'd0);

    // CDB wakeup, then dispatch-cycle bypass.
    disp(4'd2, 1'b0, 6'd5, 32'h0, 32'h1); cycle(); idle();
    cycle();
    chk("wait_no_issue", 64'(s_en), 64'd0);
    cdb(6'd5, 32'h10); cycle(); idle();
    cycle();
    chk("wake_issue_en", 64'(s_en), 64'd1);
    chk("wake_rd_a", 64'(s_a), 64'h10);
    disp(4'd2, 1'b0, 6'd5, 32'h0, 32'h1); cdb(6'd5, 32'h20); cycle(); idle();
    cycle();
    chk("bypass_issue_en", 64'(s_en), 64'd1);
    chk("bypass_rd_a", 64'(s_a), 64'h20);

    // Age order among ready entries.
    disp(4'd3, 1'b0, 6'd7, 32'h0, 32'h100); cycle();
    disp(4'd3, 1'b1, 6'd0, 32'h1, 32'h101); cycle();
    disp(4'd3, 1'b1, 6'd0, 32'h2, 32'h102); cycle();
    chk("age_i1", 64'(s_b), 64'h101);
    idle(); cycle();
    chk("age_i2", 64'(s_b), 64'h102);
    cycle();
    chk("age_i0_waits", 64'(s_en), 64'd0);
    cdb(6'd7, 32'h77); cycle(); idle();
    cycle();
    chk("age_i0_b", 64'(s_b), 64'h100);
    chk("age_i0_a", 64'(s_a), 64'h77);

    // Full: 8 waiting entries, an extra dispatch dropped, then drain in order.
    for (int k = 0; k < 8; k++) begin
      disp(4'd4, 1'b0, 6'd9, 32'h0, 32'h200 + k); cycle();
    end
    disp(4'd4, 1'b1, 6'd0, 32'h5, 32'h2ff); cycle();
    chk("full_disp_ready", 64'(s_rdy), 64'd0);
    chk("full_count", 64'(s_cnt), 64'd8);
    idle(); cdb(6'd9, 32'h99); cycle(); idle();
    for (int k = 0; k < 8; k++) begin
      cycle();
      chk("drain_en", 64'(s_en), 64'd1);
      chk("drain_order", 64'(s_b), 64'(32'h200 + k));
    end
    cycle();
    chk("drain_done", 64'(s_en), 64'd0);

    // Recovery with 5 entries (last one ready) and a same-cycle dispatch.
    for (int k = 0; k < 4; k++) begin
      disp(4'd5, 1'b0, 6'd11, 32'h0, 32'h300 + k); cycle();
    end
    disp(4'd5, 1'b1, 6'd0, 32'h1, 32'h304); cycle();
    disp(4'd5, 1'b1, 6'd0, 32'h1, 32'h305); recovery_en = 1'b1; cycle();
    chk("recovery_issue_en", 64'(s_en), 64'd0);
    idle(); cycle();
    chk("recovery_count", 64'(s_cnt), 64'd0);
    cdb(6'd11, 32'h1); cycle(); idle();
    cycle();
    chk("recovery_no_issue", 64'(s_en), 64'd0);

    // Randomized traffic against the queue model.
    for (int n = 0; n < 600; n++) begin
      idle();
      recovery_en = ($urandom_range(0, 49) == 0);
      disp_valid = ($urandom_range(0, 9) < 6);
      disp_inst = '0;
      disp_inst.op = 4'($urandom_range(0, 15));
      disp_inst.use_imm = 1'($urandom_range(0, 1));
      disp_inst.read_t = 1'($urandom_range(0, 1));
      disp_inst.p_rd = 6'($urandom_range(0, 63));
      disp_inst.imm = $urandom;
      disp_a_tag = 6'($urandom_range(0, 7));
      disp_b_tag = 6'($urandom_range(0, 7));
      disp_t_tag = 6'($urandom_range(0, 7));
      disp_a_rdy = 1'($urandom_range(0, 1));
      disp_b_rdy = 1'($urandom_range(0, 1));
      disp_t_rdy = 1'($urandom_range(0, 1));
      disp_a_val = $urandom; disp_b_val = $urandom;
      disp_t_val = 1'($urandom_range(0, 1));
      cdb_pkt.valid = ($urandom_range(0, 9) < 4);
      cdb_pkt.en = 1'($urandom_range(0, 1));
      cdb_pkt.t_en = 1'($urandom_range(0, 1));
      cdb_pkt.tag = 6'($urandom_range(0, 7));
      cdb_pkt.t_tag = 6'($urandom_range(0, 7));
      cdb_result = $urandom;
      cdb_result_t = 1'($urandom_range(0, 1));
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
